// File: rtl/prescaled_timer.sv
// Programmable up/down timer: enable-qualified prescaler, periodic or one-shot
// mode, start/stop/clear control and a one-cycle terminal-count pulse.
module prescaled_timer #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enabled,
  input  logic                      clear,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      one_shot,
  input  logic                      count_down,
  input  logic [WIDTH-1:0]          period,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [WIDTH-1:0]          value,
  output logic                      rollover,
  output logic                      running,
  output logic                      done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0]          VAL_ONE = WIDTH'(1);
  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

  state_t                    state_q, state_d;
  logic [WIDTH-1:0]          value_q, value_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      rollover_q, rollover_d;
  logic [WIDTH-1:0]          sh_period_q, sh_period_d;
  logic [PRESCALE_WIDTH-1:0] sh_pre_q, sh_pre_d;
  logic                      sh_os_q, sh_os_d;
  logic                      sh_dn_q, sh_dn_d;
  logic                      at_term;

  assign at_term = sh_dn_q ? (value_q == '0) : (value_q == sh_period_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      value_q     <= '0;
      pre_q       <= '0;
      rollover_q  <= 1'b0;
      sh_period_q <= '0;
      sh_pre_q    <= '0;
      sh_os_q     <= 1'b0;
      sh_dn_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      pre_q       <= pre_d;
      rollover_q  <= rollover_d;
      sh_period_q <= sh_period_d;
      sh_pre_q    <= sh_pre_d;
      sh_os_q     <= sh_os_d;
      sh_dn_q     <= sh_dn_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    pre_d       = pre_q;
    rollover_d  = 1'b0;
    sh_period_d = sh_period_q;
    sh_pre_d    = sh_pre_q;
    sh_os_d     = sh_os_q;
    sh_dn_d     = sh_dn_q;

    if (clear) begin
      state_d = S_IDLE;
      value_d = '0;
      pre_d   = '0;
    end else if (start) begin
      sh_period_d = period;
      sh_pre_d    = prescale;
      sh_os_d     = one_shot;
      sh_dn_d     = count_down;
      value_d     = count_down ? period : '0;
      pre_d       = '0;
      state_d     = S_RUN;
    end else if (stop && (state_q == S_RUN)) begin
      state_d = S_IDLE;
    end else if ((state_q == S_RUN) && enabled) begin
      if (pre_q == sh_pre_q) begin
        pre_d = '0;
        if (!at_term) begin
          value_d = sh_dn_q ? (value_q - VAL_ONE) : (value_q + VAL_ONE);
        end else begin
          rollover_d = 1'b1;
          // One-shot parks on the terminal value; periodic reloads.
          if (sh_os_q) state_d = S_DONE;
          else         value_d = sh_dn_q ? sh_period_q : '0;
        end
      end else begin
        pre_d = pre_q + PRE_ONE;
      end
    end
  end

  assign value    = value_q;
  assign rollover = rollover_q;
  assign running  = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_prescaled_timer.sv
// Randomized and directed bench for prescaled_timer against a step-count
// reference model (value derived arithmetically from enabled cycles since start).
module tb_prescaled_timer;
  localparam int unsigned W  = 8;
  localparam int unsigned PW = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic          clk, reset_n, enabled, clear, start, stop, one_shot, count_down;
  logic [W-1:0]  period;
  logic [PW-1:0] prescale;
  logic [W-1:0]  value;
  logic          rollover, running, done;
  logic [W+2:0]  got, exp_v;

  int checks = 0, failures = 0;

  // reference model state
  int     m_st;
  longint m_val, m_n, m_p, m_ecnt;
  bit     m_roll, m_os, m_dn;

  prescaled_timer #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clk(clk), .reset_n(reset_n), .enabled(enabled), .clear(clear),
    .start(start), .stop(stop), .one_shot(one_shot), .count_down(count_down),
    .period(period), .prescale(prescale), .value(value), .rollover(rollover),
    .running(running), .done(done)
  );

  assign got = {value, rollover, running, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_update_exp();
    exp_v = {m_val[W-1:0], m_roll, m_st == M_RUN, m_st == M_DONE};
  endtask

  task automatic model_reset();
    m_st = M_IDLE; m_val = 0; m_roll = 0; m_n = 0; m_p = 0; m_ecnt = 0;
    m_os = 0; m_dn = 0;
    model_update_exp();
  endtask

  task automatic model_edge();
    longint s, r;
    m_roll = 0;
    if (clear) begin
      m_st = M_IDLE; m_val = 0;
    end else if (start) begin
      m_os = one_shot; m_dn = count_down; m_n = period; m_p = prescale;
      m_ecnt = 0; m_st = M_RUN; m_val = m_dn ? m_n : 0;
    end else if (stop && m_st == M_RUN) begin
      m_st = M_IDLE;
    end else if (m_st == M_RUN && enabled) begin
      m_ecnt++;
      if (m_ecnt % (m_p + 1) == 0) begin
        s = m_ecnt / (m_p + 1);
        if (m_os) begin
          if (s >= m_n + 1) begin
            m_roll = 1; m_st = M_DONE; m_val = m_dn ? 0 : m_n;
          end else begin
            m_val = m_dn ? m_n - s : s;
          end
        end else begin
          r = s % (m_n + 1);
          m_val = m_dn ? m_n - r : r;
          m_roll = (r == 0);
        end
      end
    end
    model_update_exp();
  endtask

  // advance one clock: model sees the same inputs the DUT samples
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    start = 0; stop = 0; clear = 0;
  endtask

  task automatic arm(input bit os, input bit dn, input int n, input int p);
    one_shot = os; count_down = dn; period = W'(n); prescale = PW'(p);
    start = 1;
    tick();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", got, '0);
    end
    @(negedge clk); reset_n = 1;
    model_reset();
    repeat (3) tick();
    checks++;
    if (got !== exp_v) begin
      failures++; $display("FAIL reset_idle got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_periodic_up();
    int first = -1;
    enabled = 1;
    arm(0, 0, 3, 0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (rollover && first < 0) first = i;
      checks++;
      if (got !== exp_v || rollover !== (i % 4 == 0) || value !== W'(i % 4)) begin
        failures++;
        $display("FAIL periodic_up cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    checks++;
    if (first !== 4) begin
      failures++; $display("FAIL periodic_first_roll got=%0d exp=4", first);
    end
  endtask

  task automatic test_prescale_gating();
    int rolls[$];
    arm(0, 0, 2, 2);
    for (int i = 1; i <= 40; i++) begin
      enabled = (i >= 12 && i <= 16) ? 0 : 1;
      tick();
      if (rollover) rolls.push_back(i);
      checks++;
      if (got !== exp_v) begin
        failures++; $display("FAIL prescale_model cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    enabled = 1;
    checks++;
    if (rolls.size() < 3 || rolls[0] != 9 || rolls[1] - rolls[0] != 14 || rolls[2] - rolls[1] != 9) begin
      failures++;
      $display("FAIL prescale_gating got n=%0d first=%0d exp first=9 gaps=14,9",
               rolls.size(), (rolls.size() > 0) ? rolls[0] : -1);
    end
  endtask

  task automatic test_one_shot_down();
    int nroll = 0;
    arm(1, 1, 5, 0);
    checks++;
    if (value !== 5 || running !== 1 || done !== 0) begin
      failures++; $display("FAIL oneshot_start got=%h exp=%h", got, exp_v);
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      nroll += rollover;
      checks++;
      if (got !== exp_v) begin
        failures++; $display("FAIL oneshot_model cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
    checks++;
    if (nroll != 1 || done !== 1 || running !== 0 || value !== 0) begin
      failures++;
      $display("FAIL oneshot_done got rolls=%0d d=%b run=%b v=%0d exp 1 1 0 0", nroll, done, running, value);
    end
    arm(1, 1, 5, 0);
    checks++;
    if (done !== 0 || running !== 1 || value !== 5) begin
      failures++; $display("FAIL oneshot_rearm got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_controls();
    arm(0, 0, 20, 0);
    repeat (7) tick();
    stop = 1;
    tick();
    repeat (3) tick();
    checks++;
    if (value !== 7 || running !== 0 || got !== exp_v) begin
      failures++; $display("FAIL stop_hold got v=%0d run=%b exp v=7 run=0", value, running);
    end
    clear = 1;
    tick();
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL clear got=%h exp=%h", got, '0);
    end
    arm(0, 0, 3, 0);
    repeat (3) tick();
    arm(0, 0, 3, 0);
    checks++;
    if (value !== 0 || rollover !== 0 || running !== 1 || got !== exp_v) begin
      failures++; $display("FAIL start_on_terminal got=%h exp v=0 r=0 run=1", got);
    end
    clear = 1; start = 1;
    tick();
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL clear_and_start got=%h exp=%h", got, '0);
    end
  endtask

  task automatic test_edge_cases();
    int bad = 0;
    arm(0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (rollover !== 1 || value !== 0 || got !== exp_v) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL period_zero got bad_cycles=%0d exp 0", bad);
    end
    arm(0, 0, (1 << W) - 1, 0);
    bad = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (got !== exp_v || rollover !== 0) bad++;
    end
    checks++;
    if (bad != 0 || value !== W'((1 << W) - 1)) begin
      failures++; $display("FAIL max_period_climb got bad=%0d v=%0d exp 0 %0d", bad, value, (1 << W) - 1);
    end
    tick();
    checks++;
    if (value !== 0 || rollover !== 1 || running !== 1 || got !== exp_v) begin
      failures++; $display("FAIL max_period_wrap got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_async_reset();
    arm(0, 1, 50, 1);
    repeat (10) tick();
    #2 reset_n = 0;
    model_reset();
    #1;
    checks++;
    if (got !== '0) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", got, '0);
    end
    #2 reset_n = 1;
    repeat (4) tick();
    checks++;
    if (got !== '0 || got !== exp_v) begin
      failures++; $display("FAIL reset_release_idle got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(0, 15) == 0);
      stop       = ($urandom_range(0, 31) == 0);
      clear      = ($urandom_range(0, 63) == 0);
      enabled    = ($urandom_range(0, 3) != 0);
      one_shot   = $urandom_range(0, 1);
      count_down = $urandom_range(0, 1);
      period     = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      prescale   = PW'($urandom_range(0, 3));
      tick();
      checks++;
      if (got !== exp_v) begin
        failures++; bad++;
        if (bad <= 5) $display("FAIL random cyc=%0d got=%h exp=%h", i, got, exp_v);
      end
    end
  endtask

  initial begin
    reset_n = 0; enabled = 0; clear = 0; start = 0; stop = 0;
    one_shot = 0; count_down = 0; period = '0; prescale = '0;
    model_reset();
    test_reset();
    test_periodic_up();
    test_prescale_gating();
    test_one_shot_down();
    test_controls();
    test_edge_cases();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
